mor1kx_spr_access_ctrl_cappuccino: RTL
======================================

# mor1kx_spr_access_ctrl_cappuccino

Sequencer and arbiter for the single SPR bus in the cappuccino pipeline. It serves two requesters: the ctrl-stage l.mfspr/l.mtspr instruction and the debug unit. It runs one bus transaction at a time with a timeout. It returns the ctrl-stage `ctrl_mfspr_ack`/`ctrl_mtspr_ack` handshake that releases the ctrl-stage stall, and a separate ack for the debug unit.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, SPR data width
- OPTION_SPR_ADDR_WIDTH, 16, SPR address width
- SPR_TIMEOUT, 32, max bus cycles without ack (1..255)

Ports (all 1 bit unless given):
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-high (`OR_ASYNC_RST` style)
- padv_ctrl_i  in  ctrl stage advances this cycle
- pipeline_flush_i  in  pipeline flush
- ctrl_op_mfspr_i / ctrl_op_mtspr_i  in  ctrl-stage SPR op valid
- ctrl_spr_addr_i  in  OPTION_SPR_ADDR_WIDTH  pipeline SPR address
- ctrl_spr_wdata_i  in  OPTION_OPERAND_WIDTH  pipeline write data
- ctrl_mfspr_ack_o / ctrl_mtspr_ack_o  out  level ack to ctrl stage
- ctrl_mfspr_rdata_o  out  OPTION_OPERAND_WIDTH  mfspr result
- du_stall_i  in  CPU halted by debugger
- du_stb_i, du_we_i  in  debug request strobe / write
- du_addr_i  in  OPTION_SPR_ADDR_WIDTH;  du_dat_i  in  OPTION_OPERAND_WIDTH
- du_ack_o  out  1-cycle debug ack;  du_dat_o  out  OPTION_OPERAND_WIDTH
- spr_bus_stb_o, spr_bus_we_o  out  bus strobe / write
- spr_bus_addr_o  out  OPTION_SPR_ADDR_WIDTH;  spr_bus_dat_o  out  OPTION_OPERAND_WIDTH
- spr_bus_dat_i  in  OPTION_OPERAND_WIDTH;  spr_bus_ack_i  in  slave ack
- spr_timeout_o  out  1-cycle pulse on timed-out access

## Operation
- States: IDLE, PIPE_BUS, PIPE_DONE, DBG_BUS, DBG_DONE. All outputs are registered. Reset puts the block in IDLE with every output 0 and the timeout counter at 0.
- IDLE arbitration:
  - Pipeline request is `(ctrl_op_mfspr_i|ctrl_op_mtspr_i) & !pipeline_flush_i`.
  - If du_stall_i=1: only du_stb_i is served, to DBG_BUS.
  - Otherwise: a pipeline request wins and goes to PIPE_BUS; else du_stb_i goes to DBG_BUS.
  - On entry, latch addr, data and we into the bus outputs. Pipeline we = ctrl_op_mtspr_i. Assert spr_bus_stb_o.
- PIPE_BUS / DBG_BUS:
  - Hold stb, addr, data and we stable.
  - The 8-bit counter increments each stb cycle.
  - Termination: spr_bus_ack_i=1, or counter == SPR_TIMEOUT-1 without ack. The timeout case also pulses spr_timeout_o and uses read data 0.
  - On termination: stb low, counter 0, capture read data (spr_bus_dat_i or 0).
- PIPE_BUS termination:
  - Flush seen at any point during PIPE_BUS: result discarded, no ctrl ack, go to IDLE.
  - Otherwise go to PIPE_DONE with ctrl_mfspr_ack_o or ctrl_mtspr_ack_o = 1 (matching the op) and ctrl_mfspr_rdata_o = captured data.
- PIPE_DONE:
  - Ack holds high until padv_ctrl_i or pipeline_flush_i. On that edge, ack goes to 0 and the state goes to IDLE.
  - ctrl_mfspr_rdata_o holds until the next mfspr completes.
- DBG_BUS termination: go to DBG_DONE with du_ack_o=1 and du_dat_o = captured data.
- DBG_DONE:
  - Lasts one cycle; du_ack_o falls and the state goes to IDLE.
  - du_stb_i is ignored here so a request is never reissued.
- A bus transaction is never aborted once stb is asserted. Flush and a change in du_stall_i take effect only at IDLE.
- Async rst mid-transaction: immediate IDLE, stb 0, all acks 0.

## Timing
- Request sampled at edge E0 → stb high in cycle after E0.
- Zero-wait slave acks in first stb cycle → ctrl/du ack high the following cycle.
- Minimum latency is 2 cycles from request to ack.
- Timeout: stb high for exactly SPR_TIMEOUT cycles, then ack with data 0 plus the spr_timeout_o pulse in the same cycle.
- Back-to-back: after PIPE_DONE→IDLE, the next request starts stb no earlier than 1 cycle later. Peak throughput is one access per 3 cycles.
- spr_bus_ack_i outside a BUS state is ignored.

## Test plan
- mtspr addr 0x0011, data 0xDEADBEEF, zero-wait slave → stb 1 cycle with we=1, ctrl_mtspr_ack_o high 2 cycles after request, held until padv_ctrl_i, then 0.
- mfspr with slave ack after 3 waits, data 0x12345678 → stb 4 cycles, ctrl_mfspr_rdata_o=0x12345678, ack held until padv_ctrl_i.
- SPR_TIMEOUT=4, slave never acks → stb exactly 4 cycles, spr_timeout_o pulse, ctrl ack with rdata 0.
- Simultaneous mfspr and du_stb_i in IDLE: with du_stall_i=0, pipeline served first, debug served after PIPE_DONE exits. With du_stall_i=1, debug served, pipeline waits.
- pipeline_flush_i in 2nd stb cycle of mfspr → bus completes on slave ack, no ctrl ack ever asserted, IDLE afterward.
- Debug read of 0x0020 returning 0xA5A5A5A5, du_stb_i held until ack → du_ack_o exactly 1 cycle, du_dat_o=0xA5A5A5A5, only one stb transaction; rst asserted mid-access → stb and all acks 0 immediately.

Source files
------------

// File: rtl/mor1kx_spr_access_ctrl_cappuccino.sv
// SPR bus sequencer/arbiter for the cappuccino pipeline.
// Serves the ctrl-stage l.mfspr/l.mtspr and the debug unit, one bus
// transaction at a time, with a bounded wait for the slave ack.
// All outputs come straight from registers.

module mor1kx_spr_access_ctrl_cappuccino #(
    parameter int OPTION_OPERAND_WIDTH  = 32,
    parameter int OPTION_SPR_ADDR_WIDTH = 16,
    parameter int SPR_TIMEOUT           = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             padv_ctrl_i,
    input  logic                             pipeline_flush_i,
    input  logic                             ctrl_op_mfspr_i,
    input  logic                             ctrl_op_mtspr_i,
    input  logic [OPTION_SPR_ADDR_WIDTH-1:0] ctrl_spr_addr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  ctrl_spr_wdata_i,
    output logic                             ctrl_mfspr_ack_o,
    output logic                             ctrl_mtspr_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]  ctrl_mfspr_rdata_o,
    input  logic                             du_stall_i,
    input  logic                             du_stb_i,
    input  logic                             du_we_i,
    input  logic [OPTION_SPR_ADDR_WIDTH-1:0] du_addr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  du_dat_i,
    output logic                             du_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]  du_dat_o,
    output logic                             spr_bus_stb_o,
    output logic                             spr_bus_we_o,
    output logic [OPTION_SPR_ADDR_WIDTH-1:0] spr_bus_addr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]  spr_bus_dat_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_bus_dat_i,
    input  logic                             spr_bus_ack_i,
    output logic                             spr_timeout_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PIPE_BUS  = 3'd1,
        ST_PIPE_DONE = 3'd2,
        ST_DBG_BUS   = 3'd3,
        ST_DBG_DONE  = 3'd4
    } state_t;

    // Last counter value before the access is abandoned; the counter is 0
    // in the first strobe cycle, so the strobe lasts SPR_TIMEOUT cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(SPR_TIMEOUT - 1);

    state_t                            r_state,       w_state;
    logic [7:0]                        r_cnt,         w_cnt;
    logic                              r_stb,         w_stb;
    logic                              r_we,          w_we;
    logic [OPTION_SPR_ADDR_WIDTH-1:0]  r_addr,        w_addr;
    logic [OPTION_OPERAND_WIDTH-1:0]   r_wdat,        w_wdat;
    logic                              r_op_mtspr,    w_op_mtspr;
    logic                              r_flush_seen,  w_flush_seen;
    logic                              r_mfspr_ack,   w_mfspr_ack;
    logic                              r_mtspr_ack,   w_mtspr_ack;
    logic [OPTION_OPERAND_WIDTH-1:0]   r_mfspr_rdata, w_mfspr_rdata;
    logic                              r_du_ack,      w_du_ack;
    logic [OPTION_OPERAND_WIDTH-1:0]   r_du_dat,      w_du_dat;
    logic                              r_timeout,     w_timeout;

    logic                              w_pipe_req;
    logic                              w_bus_done;
    logic [OPTION_OPERAND_WIDTH-1:0]   w_rdata;

    // A flushed instruction never starts a bus access.
    assign w_pipe_req = (ctrl_op_mfspr_i | ctrl_op_mtspr_i) & ~pipeline_flush_i;
    // Access ends on slave ack or when the wait budget is used up.
    assign w_bus_done = spr_bus_ack_i | (r_cnt == TIMEOUT_LAST);
    // A timed-out access returns zero.
    assign w_rdata    = spr_bus_ack_i ? spr_bus_dat_i : {OPTION_OPERAND_WIDTH{1'b0}};

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_stb         = r_stb;
        w_we          = r_we;
        w_addr        = r_addr;
        w_wdat        = r_wdat;
        w_op_mtspr    = r_op_mtspr;
        w_flush_seen  = r_flush_seen;
        w_mfspr_ack   = r_mfspr_ack;
        w_mtspr_ack   = r_mtspr_ack;
        w_mfspr_rdata = r_mfspr_rdata;
        w_du_ack      = 1'b0;
        w_du_dat      = r_du_dat;
        w_timeout     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // While halted by the debugger only debug accesses run;
                // otherwise the pipeline has priority.
                if (!du_stall_i && w_pipe_req) begin
                    w_state      = ST_PIPE_BUS;
                    w_stb        = 1'b1;
                    w_we         = ctrl_op_mtspr_i;
                    w_addr       = ctrl_spr_addr_i;
                    w_wdat       = ctrl_spr_wdata_i;
                    w_op_mtspr   = ctrl_op_mtspr_i;
                    w_flush_seen = 1'b0;
                    w_cnt        = 8'd0;
                end else if (du_stb_i) begin
                    w_state = ST_DBG_BUS;
                    w_stb   = 1'b1;
                    w_we    = du_we_i;
                    w_addr  = du_addr_i;
                    w_wdat  = du_dat_i;
                    w_cnt   = 8'd0;
                end else begin
                    w_state = ST_IDLE;
                end
            end

            ST_PIPE_BUS: begin
                if (w_bus_done) begin
                    w_stb     = 1'b0;
                    w_cnt     = 8'd0;
                    w_timeout = ~spr_bus_ack_i;
                    if (r_flush_seen || pipeline_flush_i) begin
                        // Instruction was flushed: drop the result silently.
                        w_state = ST_IDLE;
                    end else if (r_op_mtspr) begin
                        w_state     = ST_PIPE_DONE;
                        w_mtspr_ack = 1'b1;
                    end else begin
                        w_state       = ST_PIPE_DONE;
                        w_mfspr_ack   = 1'b1;
                        w_mfspr_rdata = w_rdata;
                    end
                end else begin
                    w_cnt        = r_cnt + 8'd1;
                    w_flush_seen = r_flush_seen | pipeline_flush_i;
                end
            end

            ST_PIPE_DONE: begin
                // Ack is a level that releases the ctrl stall until it moves.
                if (padv_ctrl_i || pipeline_flush_i) begin
                    w_state     = ST_IDLE;
                    w_mfspr_ack = 1'b0;
                    w_mtspr_ack = 1'b0;
                end else begin
                    w_state = ST_PIPE_DONE;
                end
            end

            ST_DBG_BUS: begin
                if (w_bus_done) begin
                    w_state   = ST_DBG_DONE;
                    w_stb     = 1'b0;
                    w_cnt     = 8'd0;
                    w_timeout = ~spr_bus_ack_i;
                    w_du_ack  = 1'b1;
                    w_du_dat  = w_rdata;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end

            ST_DBG_DONE: begin
                // One dead cycle so a still-held du_stb_i is not reissued.
                w_state = ST_IDLE;
            end

            default: begin
                w_state     = ST_IDLE;
                w_stb       = 1'b0;
                w_cnt       = 8'd0;
                w_mfspr_ack = 1'b0;
                w_mtspr_ack = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_stb         <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= {OPTION_SPR_ADDR_WIDTH{1'b0}};
            r_wdat        <= {OPTION_OPERAND_WIDTH{1'b0}};
            r_op_mtspr    <= 1'b0;
            r_flush_seen  <= 1'b0;
            r_mfspr_ack   <= 1'b0;
            r_mtspr_ack   <= 1'b0;
            r_mfspr_rdata <= {OPTION_OPERAND_WIDTH{1'b0}};
            r_du_ack      <= 1'b0;
            r_du_dat      <= {OPTION_OPERAND_WIDTH{1'b0}};
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_stb         <= w_stb;
            r_we          <= w_we;
            r_addr        <= w_addr;
            r_wdat        <= w_wdat;
            r_op_mtspr    <= w_op_mtspr;
            r_flush_seen  <= w_flush_seen;
            r_mfspr_ack   <= w_mfspr_ack;
            r_mtspr_ack   <= w_mtspr_ack;
            r_mfspr_rdata <= w_mfspr_rdata;
            r_du_ack      <= w_du_ack;
            r_du_dat      <= w_du_dat;
            r_timeout     <= w_timeout;
        end
    end

    assign ctrl_mfspr_ack_o   = r_mfspr_ack;
    assign ctrl_mtspr_ack_o   = r_mtspr_ack;
    assign ctrl_mfspr_rdata_o = r_mfspr_rdata;
    assign du_ack_o           = r_du_ack;
    assign du_dat_o           = r_du_dat;
    assign spr_bus_stb_o      = r_stb;
    assign spr_bus_we_o       = r_we;
    assign spr_bus_addr_o     = r_addr;
    assign spr_bus_dat_o      = r_wdat;
    assign spr_timeout_o      = r_timeout;

endmodule
